// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op encodings, FSM states and step-counter sizing.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix,
        StDone
    } state_e;

    localparam int unsigned WIDTH_DEFAULT = 32;
    localparam int unsigned CNT_W         = $clog2(WIDTH_DEFAULT) + 1;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on a 2*WIDTH accumulator.
// Divide datapath present only when MULDIV_DIV_EN is defined.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   mul_next;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    always_comb begin
        sum      = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        mul_next = {sum, acc_i[WIDTH-1:1]};
    end

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   diff;
    logic               ge;
    logic [2*WIDTH-1:0] div_next;

    // Divide: acc = {remainder, dividend bits shifting into quotient}.
    // A compare rather than the borrow bit keeps a zero divisor accumulating |a| in the remainder.
    always_comb begin
        shifted  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        ge       = shifted >= {1'b0, opnd_i};
        diff     = shifted[WIDTH-1:0] - opnd_i;
        div_next = {(ge ? diff : shifted[WIDTH-1:0]), acc_i[WIDTH-2:0], ge};
    end

    assign acc_o = is_div_i ? div_next : mul_next;
`else
    logic unused_is_div;
    assign unused_is_div = is_div_i;
    assign acc_o         = mul_next;
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers and a one-cycle done pulse.
// Define MULDIV_DIV_EN to include the divider; otherwise divide ops complete as no-ops.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, step_acc;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               res_neg_q, res_neg_d;
    logic               step_is_div;

    op_e                op_sel;
    logic               is_signed, is_div_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

`ifdef MULDIV_DIV_EN
    logic               is_div_q, is_div_d;
    logic               rem_neg_q, rem_neg_d;
    logic               dz_q, dz_d;
    assign step_is_div = is_div_q;
`else
    assign step_is_div = 1'b0;
`endif

    assign op_sel    = op_e'(op);
    assign is_signed = (op_sel == OP_MULT) || (op_sel == OP_DIV);
    assign is_div_op = (op_sel == OP_DIVU) || (op_sel == OP_DIV);
    assign a_neg     = is_signed & a[WIDTH-1];
    assign b_neg     = is_signed & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div_i (step_is_div),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        res_neg_d = res_neg_q;
`ifdef MULDIV_DIV_EN
        is_div_d  = is_div_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
`endif

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    cnt_d     = '0;
                    res_neg_d = a_neg ^ b_neg;
                    if (is_div_op) begin
`ifdef MULDIV_DIV_EN
                        state_d   = StRun;
                        acc_d     = {{WIDTH{1'b0}}, a_mag};
                        opnd_d    = b_mag;
                        is_div_d  = 1'b1;
                        rem_neg_d = a_neg;
                        dz_d      = (b == '0);
`else
                        state_d = StDone;
`endif
                    end else begin
                        state_d = StRun;
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        opnd_d  = a_mag;
`ifdef MULDIV_DIV_EN
                        is_div_d = 1'b0;
`endif
                    end
                end
            end
            StRun: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StDone;
`ifdef MULDIV_DIV_EN
                if (is_div_q) begin
                    lo_d = dz_q ? '1 : (res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
                    // A zero divisor leaves |a| here; restoring the dividend sign yields a.
                    hi_d = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else
`endif
                begin
                    {hi_d, lo_d} = res_neg_q ? -acc_q : acc_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            res_neg_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q  <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            res_neg_q <= res_neg_d;
`ifdef MULDIV_DIV_EN
            is_div_q  <= is_div_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
`endif
        end
    end

    assign busy = (state_q == StRun) || (state_q == StFix);
    assign done = (state_q == StDone);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit; divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    typedef struct {
        string      tag;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int         lat;
        int         busy_cycles;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] cur_hi, cur_lo;
    int           checks;
    int           errors;

    muldiv_unit #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] ra,
                          input logic [W-1:0] rb, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input int poke_at);
        exp_t e;
        exp_t got;
        int   n;
        int   busy_n;
        e.tag         = tag;
        e.hi          = ehi;
        e.lo          = elo;
        e.lat         = W + 1;
        e.busy_cycles = W + 1;
`ifndef MULDIV_DIV_EN
        if (o[1]) begin
            e.hi          = cur_hi;
            e.lo          = cur_lo;
            e.lat         = 0;
            e.busy_cycles = 0;
        end
`endif
        sb.push_back(e);
        cur_hi = e.hi;
        cur_lo = e.lo;
        start = 1'b1;
        op    = o;
        a     = ra;
        b     = rb;
        @(negedge clk);
        n      = 0;
        busy_n = 0;
        while (!done && n < 200) begin
            if (busy) busy_n++;
            if (n == poke_at) begin
                start = 1'b1;
                op    = 2'b10;
                a     = 32'd9;
                b     = 32'd3;
            end else begin
                start = 1'b0;
                op    = 2'($urandom_range(0, 3));
                a     = $urandom;
                b     = $urandom;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        got = sb.pop_front();
        check({got.tag, ".done"}, {63'd0, done}, 64'd1);
        check({got.tag, ".busy_at_done"}, {63'd0, busy}, 64'd0);
        check({got.tag, ".hi"}, {32'd0, hi}, {32'd0, got.hi});
        check({got.tag, ".lo"}, {32'd0, lo}, {32'd0, got.lo});
        check({got.tag, ".latency"}, 64'(n), 64'(got.lat));
        check({got.tag, ".busy_cycles"}, 64'(busy_n), 64'(got.busy_cycles));
    endtask

    initial begin
        bit seen;
        checks = 0;
        errors = 0;
        cur_hi = '0;
        cur_lo = '0;
        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;
        repeat (3) @(negedge clk);
        check("reset.busy", {63'd0, busy}, 64'd0);
        check("reset.done", {63'd0, done}, 64'd0);
        check("reset.hi", {32'd0, hi}, 64'd0);
        check("reset.lo", {32'd0, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("multu_7x6",   2'b00, 32'd7,        32'd6,        32'h0,        32'h2A,       -1);
        run_op("mult_m3x5",   2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, -1);
        run_op("divu_100_7",  2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       -1);
        run_op("div_m7_2",    2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, -1);
        run_op("div_5_0",     2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, -1);
        run_op("div_m5_0",    2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, -1);
        run_op("div_ovf",     2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, -1);
        run_op("divu_big_0",  2'b10, 32'h80000001, 32'd0,        32'h80000001, 32'hFFFFFFFF, -1);
        run_op("divu_max_16", 2'b10, 32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, -1);
        run_op("multu_max",   2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, -1);
        run_op("mult_min2",   2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        -1);
        run_op("mult_7xm2",   2'b01, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, -1);
        @(negedge clk);
        run_op("multu_poke",  2'b00, 32'd3,        32'd4,        32'h0,        32'hC,        10);
        run_op("multu_2x3",   2'b00, 32'd2,        32'd3,        32'h0,        32'h6,        -1);
        run_op("divu_9_3",    2'b10, 32'd9,        32'd3,        32'h0,        32'h3,        -1);

        // Reset partway through a multiply.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd3;
        b     = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset.busy", {63'd0, busy}, 64'd0);
        check("midreset.done", {63'd0, done}, 64'd0);
        check("midreset.hi", {32'd0, hi}, 64'd0);
        check("midreset.lo", {32'd0, lo}, 64'd0);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("midreset.no_done", {63'd0, seen}, 64'd0);
        cur_hi = '0;
        cur_lo = '0;

        run_op("multu_after_reset", 2'b00, 32'h12345678, 32'h10, 32'h1, 32'h23456780, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS core, sitting beside the ALU in the datapath and consuming register-file operands for `mult`, `multu`, `div` and `divu`. It runs one shift-add or restoring-subtract step per clock, holds results in architectural HI/LO registers, and signals completion with a one-cycle `done` pulse. The controller stalls the pipeline on `busy` and reads HI/LO for `mfhi`/`mflo`.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  launch an operation; sampled only when `busy`=0.
- `op`  in  2  operation: 00 multu, 01 mult, 10 divu, 11 div.
- `a`  in  WIDTH  rs operand: multiplicand or dividend.
- `b`  in  WIDTH  rt operand: multiplier or divisor.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; HI/LO are valid in this cycle.
- `hi`  out  WIDTH  HI register: product high word, or remainder.
- `lo`  out  WIDTH  LO register: product low word, or quotient.

## Operation
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, FSM in IDLE.
- FSM states:
  - IDLE: on `start`, latch |a|, |b| (magnitudes for signed ops), the sign flags, op and zero-divisor flag; go to RUN; clear step counter.
  - RUN: one step per cycle; after WIDTH steps go to FIX.
  - FIX: apply sign correction, write HI/LO; go to DONE.
  - DONE: `done`=1 for this cycle; return to IDLE. `start` is accepted in DONE as if in IDLE.
- Multiply: shift-add over a 2·WIDTH accumulator. Signed result is the magnitude product, negated in two's complement when the operand signs differ.
- Divide: restoring algorithm on magnitudes.
  - Signed quotient is negated when the signs differ.
  - Signed remainder takes the dividend's sign.
- Divide by zero (either op): LO=all ones, HI=`a` unchanged; sign fixup is skipped.
- Signed overflow (−2^(WIDTH−1) / −1): LO=0x80000000, HI=0, which is the natural wrap of the magnitude path.
- `start` while busy is ignored; the operation in flight is unaffected.
- `op`, `a` and `b` are don't-care except in the cycle `start` is accepted.
- HI/LO change only on the FIX→DONE edge. Between operations they hold their values for `mfhi`/`mflo`.

## Timing
- `start` is accepted at edge 0, and `busy` rises after edge 0.
- Steps execute at edges 1..WIDTH.
- The FIX write happens at edge WIDTH+1. After that edge `busy`=0, `done`=1, and HI/LO hold the new values.
- Total latency is WIDTH+1 cycles (33 at default); the next operation can start in the `done` cycle.
- `busy` and `done` are never high simultaneously.
- `reset` asserted mid-operation forces all reset values at the next edge. No partial result reaches HI/LO.

## Configuration
- `MULDIV_DIV_EN` defined: divider datapath and divide ops are present as described.
- `MULDIV_DIV_EN` undefined:
  - Ops 10/11 are accepted but perform no work: the FSM goes IDLE→DONE, so `done` pulses one cycle after `start`.
  - HI/LO are unchanged.
  - No divider logic is synthesised.

## Structure
- Package `muldiv_pkg`: op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV), FSM state encoding, and the step-counter width constant `CNT_W` = clog2(WIDTH)+1.
- One combinational sub-module `muldiv_step`: computes the next accumulator/remainder/quotient for a single iteration from the current state and op. The top level keeps the FSM, counter, sign flags and HI/LO.

## Test plan
- multu a=7, b=6 → `done` exactly 33 cycles after `start`; HI=0x00000000, LO=0x0000002A; `busy` high cycles 1–33.
- mult a=0xFFFFFFFD (−3), b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- divu a=100, b=7 → LO=14, HI=2.
- div cases:
  - a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - a=5, b=0 → LO=0xFFFFFFFF, HI=5.
  - a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- multu 3×4 started, second `start` (divu 9/3) at cycle 10 → ignored; result HI=0, LO=12. `reset` at cycle 20 of a new multu → next edge `busy`=0, `done`=0, HI=LO=0, and `done` never pulses.
- Without `MULDIV_DIV_EN`: with HI/LO preloaded by multu 2×3, issue divu 9/3 → `done` one cycle after `start`, HI=0, LO=6 unchanged.
